mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory access sequencer for the RISC-V multicycle processor.
- Sits directly downstream of the multicycle control FSM and datapath. It turns the FSM's fetch, load and store requests into transactions on a single-port unified instruction/data memory.
- The memory has a variable-latency ack. The block handles byte-lane alignment, load sign/zero extension, alignment checks and ack timeout.
- It holds the instruction register (IR) and the load-data register consumed by writeback.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles without mem_ack before the request is aborted with error.
- IR_RESET, 32'h0000_0013: IR value after reset (NOP, addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  FSM request; held high until done.
- req_fetch  in  1  1 = instruction fetch (word read into IR); 0 = data access.
- req_we  in  1  1 = store; ignored when req_fetch=1.
- req_funct3  in  3  access size/sign, RISC-V load/store encoding; ignored for fetch.
- req_addr  in  32  byte address (PC or ALUOut).
- req_wdata  in  32  store data, right-aligned.
- done  out  1  one-cycle pulse: request finished (success or error).
- err  out  1  one-cycle pulse with done: misaligned, illegal funct3 or timeout.
- rdata  out  32  extended load data; valid from the done cycle, held until the next successful load.
- ir  out  32  instruction register; updated only by a successful fetch.
- mem_en  out  1  memory request strobe; high for the whole WAIT state.
- mem_we  out  1  memory write.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read data; sampled on the mem_ack cycle.
- mem_ack  in  1  memory completion.

Behaviour:
- Reset values (rst sampled high on a clk edge): state IDLE, done=0, err=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rdata=0, ir=IR_RESET, timeout counter=0.
- Reset mid-transaction: the request is abandoned, no done pulse is produced, and a late mem_ack is ignored.
- All outputs are registered.
- States: IDLE, WAIT, DONE, ERR.
- IDLE: when req_valid=1, latch all req_* fields, then check the request:
  - Illegal if funct3 is one of 011, 110, 111 (data access only).
  - Misaligned if: halfword with addr[0]=1; word with addr[1:0]!=0; fetch with addr[1:0]!=0.
  - Illegal or misaligned -> ERR. Otherwise -> WAIT, with mem_en=1 from the next cycle.
- WAIT: mem_en, mem_we, mem_addr, mem_be and mem_wdata are held stable.
  - On mem_ack=1 -> DONE. Fetch: ir<=mem_rdata. Load: rdata<=extended lane. Store: rdata unchanged.
  - Counter increments each WAIT cycle without ack. If the counter reaches TIMEOUT-1 and there is no ack that cycle -> ERR.
  - Ack in the limit cycle wins (completes as success).
  - Counter clears on leaving WAIT.
- DONE: done=1, err=0, mem_en=0 -> IDLE.
- ERR: done=1, err=1, mem_en=0, no memory access, rdata and ir unchanged -> IDLE.
- Latency: a request accepted at cycle T with mem_ack at T+1 gives done at T+2. Each extra wait cycle adds 1.
- Back-to-back requests: at least one IDLE cycle between done and the next acceptance.
- Byte lanes (o = addr[1:0]):
  - Byte access: be = 4'b0001<<o, wdata = {4{wdata[7:0]}}.
  - Halfword access: be = 4'b0011<<(2*addr[1]), wdata = {2{wdata[15:0]}}.
  - Word access or fetch: be = 4'b1111.
  - mem_we=0 and be=4'b1111 for fetch and loads.
- Load extension:
  - LB: sign-extend byte lane o.
  - LBU: zero-extend byte lane o.
  - LH: sign-extend half lane addr[1].
  - LHU: zero-extend half lane addr[1].
  - LW: full word.
- mem_ack outside WAIT is ignored.
- req_valid dropping while in WAIT does not cancel the transaction.

Test Plan:
1. Fetch: addr=0x0040_0008, mem_rdata=0x0050_0093, ack one cycle after mem_en -> mem_addr=0x0040_0008, be=1111, done two cycles after accept, ir=0x0050_0093, err=0.
2. LB: addr=0x1001_0003, mem_rdata=0x80FF_1234, 3-cycle ack delay -> rdata=0xFFFF_FF80, done 4 cycles after accept. LBU at the same address -> rdata=0x0000_0080.
3. SH: addr=0x1001_0002, wdata=0xDEAD_BEEF -> mem_we=1, be=1100, mem_wdata=0xBEEF_BEEF, rdata unchanged.
4. LW at addr=0x1001_0006 -> ERR: done=err=1, mem_en never asserted, rdata unchanged. funct3=3'b011 at an aligned address -> same result.
5. Timeout: fetch with mem_ack never asserted -> mem_en high for exactly 16 cycles, then done=err=1, ir unchanged.
6. rst=1 during WAIT, then ack on the next cycle -> no done, state IDLE, ir=0x0000_0013, rdata=0. A new request then completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access sequencer between the multicycle control FSM and a
// single-port unified instruction/data memory with variable-latency ack.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/fetch/we/...   request from the control FSM (held until done)
//   done, err                one-cycle completion pulse, error qualifier
//   rdata                    extended load data for writeback
//   ir                       instruction register
//   mem_en/we/addr/be/wdata  memory request (held for the whole WAIT state)
//   mem_rdata, mem_ack       memory response
module mem_access_unit #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] IR_RESET = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_fetch,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] ir,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fetch_q, fetch_d;
  logic               we_q, we_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         off_q, off_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        ir_q, ir_d;

  // Incoming request decode: access size, legality and byte lanes.
  logic [1:0]  req_size;
  logic        req_bad;
  logic [3:0]  req_be;
  logic [31:0] req_lanes;

  always_comb begin
    req_size  = req_fetch ? 2'b10 : req_funct3[1:0];
    req_bad   = 1'b0;
    req_be    = 4'b1111;
    req_lanes = req_wdata;
    if (!req_fetch && (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                       req_funct3 == 3'b111)) begin
      req_bad = 1'b1;
    end
    if ((req_size == 2'b01 && req_addr[0]) ||
        (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
      req_bad = 1'b1;
    end
    case (req_size)
      2'b00: begin
        req_be    = 4'b0001 << req_addr[1:0];
        req_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        req_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_lanes = req_wdata;
      end
    endcase
    // Reads always enable all four lanes; extraction happens on return.
    if (req_fetch || !req_we) req_be = 4'b1111;
  end

  // Load data extraction and extension from the latched offset/funct3.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fetch_d     = fetch_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    ir_d        = ir_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          fetch_d  = req_fetch;
          we_d     = !req_fetch && req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          if (req_bad) begin
            state_d = S_ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = S_WAIT;
            mem_en_d    = 1'b1;
            mem_we_d    = !req_fetch && req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = req_be;
            mem_wdata_d = req_lanes;
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          cnt_d    = '0;
          if (fetch_q)    ir_d    = mem_rdata;
          else if (!we_q) rdata_d = ld_ext;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = S_ERR;
          done_d   = 1'b1;
          err_d    = 1'b1;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fetch_q     <= 1'b0;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ir_q        <= IR_RESET;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fetch_q     <= fetch_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ir_q        <= ir_d;
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign ir        = ir_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan cases plus
// randomized requests checked against a transaction-level reference model.
module tb_mem_access_unit;

  localparam int unsigned TIMEOUT  = 16;
  localparam logic [31:0] IR_RESET = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_fetch, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        done, err;
  logic [31:0] rdata, ir;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  // Reference model architectural state.
  logic [31:0] model_ir;
  logic [31:0] model_rdata;

  mem_access_unit #(.TIMEOUT(TIMEOUT), .IR_RESET(IR_RESET)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_fetch(req_fetch), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .rdata(rdata), .ir(ir),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected extended load result, from the ISA definition.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] m);
    logic [31:0] b, h;
    b = (m >> (8 * off)) & 32'h0000_00FF;
    h = (m >> (16 * off[1])) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return m;
    endcase
  endfunction

  // One full request. delay = WAIT cycles before the ack cycle; >= TIMEOUT means no ack.
  task automatic do_req(input logic fetch, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] memval, input int delay);
    int          size;
    logic        bad;
    logic        is_store;
    logic [31:0] exp_be, exp_wd;
    logic        acked;
    size     = fetch ? 2 : int'(f3[1:0]);
    bad      = 1'b0;
    if (!fetch && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) bad = 1'b1;
    if (size == 1 && addr[0]) bad = 1'b1;
    if (size == 2 && addr[1:0] != 2'b00) bad = 1'b1;
    is_store = !fetch && we;
    exp_be   = 32'd15;
    exp_wd   = wdata;
    if (is_store && size == 0) begin
      exp_be = 32'd1 << addr[1:0];
      exp_wd = (wdata & 32'hFF) * 32'h0101_0101;
    end else if (is_store && size == 1) begin
      exp_be = 32'd3 << (2 * addr[1]);
      exp_wd = (wdata & 32'hFFFF) * 32'h0001_0001;
    end

    mem_ack    = 1'b0;
    req_valid  = 1'b1;
    req_fetch  = fetch;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    step();
    // Request fields are latched; scrambling them must not disturb the access.
    req_valid  = 1'($urandom_range(0, 1));
    req_fetch  = 1'($urandom_range(0, 1));
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    acked      = 1'b0;

    if (!bad) begin
      for (int k = 0; k < int'(TIMEOUT); k++) begin
        check("wait_mem_en", 32'(mem_en), 32'd1);
        check("wait_done", 32'(done), 32'd0);
        check("mem_we", 32'(mem_we), 32'(is_store));
        check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("mem_be", 32'(mem_be), exp_be);
        if (is_store) check("mem_wdata", mem_wdata, exp_wd);
        if (k == delay) begin
          mem_ack   = 1'b1;
          mem_rdata = memval;
          acked     = 1'b1;
          step();
          mem_ack   = 1'b0;
          break;
        end
        mem_rdata = $urandom;
        step();
      end
      if (acked && fetch) model_ir = memval;
      if (acked && !fetch && !we) model_rdata = exp_load(f3, addr[1:0], memval);
    end

    req_valid = 1'b0;
    check("done", 32'(done), 32'd1);
    check("err", 32'(err), 32'(bad || !acked));
    check("end_mem_en", 32'(mem_en), 32'd0);
    check("ir", ir, model_ir);
    check("rdata", rdata, model_rdata);
    // Acks outside WAIT must be ignored.
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    step();
    check("idle_done", 32'(done), 32'd0);
    check("idle_mem_en", 32'(mem_en), 32'd0);
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    step();
    mem_ack = 1'b0;
    check("idle_ir", ir, model_ir);
    check("idle_rdata", rdata, model_rdata);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_fetch  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    mem_rdata  = '0;
    mem_ack    = 1'b0;
    model_ir    = IR_RESET;
    model_rdata = '0;
    step();
    step();
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ir", ir, 32'h0000_0013);
    rst = 1'b0;
    step();

    // Fetch, ack one cycle after mem_en.
    do_req(1'b1, 1'b0, 3'b000, 32'h0040_0008, 32'h0, 32'h0050_0093, 0);
    check("tp1_ir", ir, 32'h0050_0093);
    // LB / LBU with ack three cycles after accept.
    do_req(1'b0, 1'b0, 3'b000, 32'h1001_0003, 32'h0, 32'h80FF_1234, 2);
    check("tp2_lb", rdata, 32'hFFFF_FF80);
    do_req(1'b0, 1'b0, 3'b100, 32'h1001_0003, 32'h0, 32'h80FF_1234, 2);
    check("tp2_lbu", rdata, 32'h0000_0080);
    // SH to upper half.
    do_req(1'b0, 1'b1, 3'b001, 32'h1001_0002, 32'hDEAD_BEEF, 32'h0, 1);
    check("tp3_rdata_kept", rdata, 32'h0000_0080);
    // Misaligned LW and illegal funct3.
    do_req(1'b0, 1'b0, 3'b010, 32'h1001_0006, 32'h0, 32'h0, 0);
    do_req(1'b0, 1'b0, 3'b011, 32'h1001_0008, 32'h0, 32'h0, 0);
    check("tp4_rdata_kept", rdata, 32'h0000_0080);
    // Ack in the limit cycle succeeds; no ack times out.
    do_req(1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'h1234_5678, int'(TIMEOUT) - 1);
    do_req(1'b1, 1'b0, 3'b000, 32'h0000_0104, 32'h0, 32'hAAAA_AAAA, int'(TIMEOUT));
    check("tp5_ir_kept", ir, 32'h1234_5678);

    // Reset in WAIT with a late ack.
    req_valid = 1'b1;
    req_fetch = 1'b1;
    req_addr  = 32'h0000_0200;
    step();
    req_valid = 1'b0;
    check("tp6_wait_mem_en", 32'(mem_en), 32'd1);
    rst = 1'b1;
    step();
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_0001;
    step();
    mem_ack = 1'b0;
    model_ir    = IR_RESET;
    model_rdata = '0;
    check("tp6_done", 32'(done), 32'd0);
    check("tp6_mem_en", 32'(mem_en), 32'd0);
    check("tp6_ir", ir, 32'h0000_0013);
    check("tp6_rdata", rdata, 32'd0);
    step();
    check("tp6_done2", 32'(done), 32'd0);
    do_req(1'b1, 1'b0, 3'b000, 32'h0000_0300, 32'h0, 32'h0010_0113, 1);
    check("tp6_after_ir", ir, 32'h0010_0113);

    // Randomized requests.
    for (int i = 0; i < 150; i++) begin
      logic        f, w;
      logic [2:0]  f3;
      logic [31:0] a;
      int          r, dly;
      f  = ($urandom_range(0, 9) < 3);
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      r   = int'($urandom_range(0, 19));
      dly = (r < 14) ? r % 4 : (r < 17) ? int'(TIMEOUT) - 1 : int'(TIMEOUT);
      do_req(f, w, f3, a, $urandom, $urandom, dly);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
